// File: rtl/conc_trace_pkg.sv
// Shared types and sizing helpers for the concolic trace recorder.
// Optional feature macro: CONC_TRACE_TIMESTAMP_EN (adds a 32-bit cycle stamp to each record).
package conc_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam int DROP_W     = 16;
  localparam int STAMP_W    = 32;
  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 31;

  // Record width for a given bus geometry; the stamp is present only when enabled.
  function automatic int rec_w(input int aw, input int dw);
`ifdef CONC_TRACE_TIMESTAMP_EN
    return STAMP_W + 2 + aw + dw;
`else
    return 2 + aw + dw;
`endif
  endfunction

  // Record layout for the default b14-class bus geometry.
  typedef struct packed {
`ifdef CONC_TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0]    stamp;
`endif
    logic                  wr;
    logic                  rd;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] datao;
  } rec_t;

endpackage

// File: rtl/conc_trace_fifo.sv
// Circular trace buffer: DEPTH x W entries, count-based full/empty.
// A push into a full buffer is accepted only when a pop happens on the same edge.
module conc_trace_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 53
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/conc_trace_recorder.sv
// Capture end of the stimulus-replay path: samples the DUT bus each clock,
// records change events into a circular buffer and drains them over valid/ready.
// Optional feature macro: CONC_TRACE_TIMESTAMP_EN (cycle stamp in each record).
module conc_trace_recorder
  import conc_trace_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 31,
  parameter int MAX_CYCLES = 500,
  localparam int REC_W     = rec_w(ADDR_W, DATA_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] dut_addr,
  input  logic [DATA_W-1:0] dut_datao,
  input  logic              dut_rd,
  input  logic              dut_wr,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [REC_W-1:0]  rec_data,
  output logic              busy,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic [31:0]       cycle
);

  localparam int          SMP_W = 2 + ADDR_W + DATA_W;
  localparam logic [31:0] LAST  = 32'(MAX_CYCLES - 1);

  state_e             state_q;
  logic               first_q;
  logic [SMP_W-1:0]   prev_q;
  logic [31:0]        cycle_q;
  logic               ovf_q;
  logic [DROP_W-1:0]  drop_q;

  logic [SMP_W-1:0]   smp_d;
  logic [REC_W-1:0]   rec_d;
  logic [REC_W-1:0]   head;
  logic               full, empty, push, pop, drop;

  assign smp_d = {dut_wr, dut_rd, dut_addr, dut_datao};
`ifdef CONC_TRACE_TIMESTAMP_EN
  assign rec_d = {cycle_q, smp_d};
`else
  assign rec_d = smp_d;
`endif

  // Change detector: first window cycle, any bus change, or an active strobe.
  assign push = (state_q == CAPTURE) &&
                (first_q || (smp_d != prev_q) || dut_rd || dut_wr);
  assign pop  = !empty && rec_ready;
  assign drop = push && full && !pop;

  conc_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (rec_d),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Window FSM with cycle counter, previous-sample register and drop accounting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      prev_q  <= '0;
      cycle_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // stop wins over a simultaneous start
          if (start && !stop) begin
            state_q <= CAPTURE;
            first_q <= 1'b1;
            cycle_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
          end
        end
        CAPTURE: begin
          first_q <= 1'b0;
          prev_q  <= smp_d;
          cycle_q <= cycle_q + 32'd1;
          if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != '1) drop_q <= drop_q + 1'b1;
          end
          if (stop || (cycle_q == LAST)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (empty) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rec_valid  = !empty;
  assign rec_data   = empty ? '0 : head;
  assign busy       = (state_q != IDLE);
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign cycle      = cycle_q;

endmodule

// File: tb/tb_conc_trace_recorder.sv
// Directed bench for conc_trace_recorder (DEPTH=4, MAX_CYCLES=24).
// Stamp fields are checked only when CONC_TRACE_TIMESTAMP_EN is defined.
module tb_conc_trace_recorder;
  import conc_trace_pkg::*;

  localparam int DEPTH      = 4;
  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 31;
  localparam int MAX_CYCLES = 24;
  localparam int REC_W      = rec_w(ADDR_W, DATA_W);

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop  = 1'b0;
  logic [ADDR_W-1:0] dut_addr  = '0;
  logic [DATA_W-1:0] dut_datao = '0;
  logic              dut_rd = 1'b0;
  logic              dut_wr = 1'b0;
  logic              rec_ready = 1'b0;
  logic              rec_valid;
  logic [REC_W-1:0]  rec_data;
  logic              busy;
  logic              overflow;
  logic [15:0]       drop_count;
  logic [31:0]       cycle;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  conc_trace_recorder #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .dut_addr   (dut_addr),
    .dut_datao  (dut_datao),
    .dut_rd     (dut_rd),
    .dut_wr     (dut_wr),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_data   (rec_data),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count),
    .cycle      (cycle)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] st);
    rec_t r;
    r = rec_t'(rec_data);
    chk({tag, ".valid"}, 128'(rec_valid), 128'(1));
    chk({tag, ".addr"}, 128'(r.addr), 128'(a));
`ifdef CONC_TRACE_TIMESTAMP_EN
    chk({tag, ".stamp"}, 128'(r.stamp), 128'(st));
`endif
  endtask

  initial begin
    rec_t e;
    int   n;

    // reset values while reset is held low
    #12;
    chk("rst.valid", 128'(rec_valid), 0);
    chk("rst.data", 128'(rec_data), 0);
    chk("rst.busy", 128'(busy), 0);
    chk("rst.ovf", 128'(overflow), 0);
    chk("rst.drop", 128'(drop_count), 0);
    chk("rst.cycle", 128'(cycle), 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // 1: constant bus -> single record, then drain to idle
    dut_addr = 20'h00010; dut_datao = 31'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1.busy", 128'(busy), 1);
    chk("t1.cycle0", 128'(cycle), 0);
    chk("t1.novalid", 128'(rec_valid), 0);
    tick();
    e = '0; e.addr = 20'h00010; e.datao = 31'd5;
    chk("t1.rec", 128'(rec_data), 128'(e));
    chk("t1.cycle1", 128'(cycle), 1);
    for (int i = 0; i < 9; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t1.one_left", 128'(rec_valid), 1);
    chk("t1.cycle11", 128'(cycle), 11);
    rec_ready = 1'b1;
    tick();
    chk("t1.popped", 128'(rec_valid), 0);
    chk("t1.busy_drain", 128'(busy), 1);
    tick();
    chk("t1.idle", 128'(busy), 0);
    chk("t1.cycle_hold", 128'(cycle), 11);

    // 2: address ramps every cycle with consumer always ready
    dut_addr = 20'h00100; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dut_addr = 20'h00100 + ADDR_W'(i);
      tick();
      chk_rec($sformatf("t2.rec%0d", i), 20'h00100 + ADDR_W'(i), 32'(i));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2.empty", 128'(rec_valid), 0);
    chk("t2.ovf", 128'(overflow), 0);
    chk("t2.cycle", 128'(cycle), 21);
    tick();
    chk("t2.idle", 128'(busy), 0);

    // 3: consumer stalled, 10 changes into a 4-deep buffer
    rec_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dut_addr = 20'h00200 + ADDR_W'(i);
      tick();
    end
    chk("t3.drop", 128'(drop_count), 6);
    chk("t3.ovf", 128'(overflow), 1);
    chk_rec("t3.head_hold", 20'h00200, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3.drop_after_stop", 128'(drop_count), 6);
    rec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_rec($sformatf("t3.rec%0d", k), 20'h00200 + ADDR_W'(k), 32'(k));
      tick();
    end
    chk("t3.empty", 128'(rec_valid), 0);
    chk("t3.busy_drain", 128'(busy), 1);
    tick();
    chk("t3.idle", 128'(busy), 0);

    // 4: full buffer with simultaneous push and pop never drops
    rec_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dut_addr = 20'h00300 + ADDR_W'(i);
      tick();
    end
    chk("t4.fill_drop", 128'(drop_count), 0);
    rec_ready = 1'b1;
    for (int i = 4; i < 12; i++) begin
      dut_addr = 20'h00300 + ADDR_W'(i);
      tick();
    end
    chk("t4.drop", 128'(drop_count), 0);
    chk("t4.ovf", 128'(overflow), 0);
    chk_rec("t4.head", 20'h00308, 8);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    chk("t4.idle", 128'(busy), 0);
    chk("t4.empty", 128'(rec_valid), 0);

    // 5: window closes itself at MAX_CYCLES; start ignored in DRAIN; start+stop in IDLE
    rec_ready = 1'b0; dut_addr = 20'h00400; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < MAX_CYCLES - 1; i++) tick();
    chk("t5.cycle_last", 128'(cycle), MAX_CYCLES - 1);
    tick();
    chk("t5.cycle_end", 128'(cycle), MAX_CYCLES);
    start = 1'b1; dut_addr = 20'h00401;
    tick();
    start = 1'b0;
    chk("t5.cycle_frozen", 128'(cycle), MAX_CYCLES);
    chk("t5.busy", 128'(busy), 1);
    chk_rec("t5.rec0", 20'h00400, 0);
    rec_ready = 1'b1;
    tick();
    chk("t5.empty", 128'(rec_valid), 0);
    tick();
    chk("t5.idle", 128'(busy), 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t5.startstop_busy", 128'(busy), 0);
    chk("t5.startstop_cycle", 128'(cycle), MAX_CYCLES);

    // 6: strobes force pushes; async reset mid-window; restart
    rec_ready = 1'b0; dut_addr = 20'h00500; dut_rd = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6.cycle5", 128'(cycle), 5);
    chk("t6.drop", 128'(drop_count), 1);
    chk("t6.ovf", 128'(overflow), 1);
    e = rec_t'(rec_data);
    chk("t6.rd_bit", 128'(e.rd), 1);
    reset = 1'b0;
    #1;
    chk("t6.rst_valid", 128'(rec_valid), 0);
    chk("t6.rst_data", 128'(rec_data), 0);
    chk("t6.rst_busy", 128'(busy), 0);
    chk("t6.rst_ovf", 128'(overflow), 0);
    chk("t6.rst_drop", 128'(drop_count), 0);
    chk("t6.rst_cycle", 128'(cycle), 0);
    @(negedge clock);
    reset = 1'b1;
    dut_rd = 1'b0; dut_addr = 20'h00600;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_rec("t6.restart", 20'h00600, 0);
    chk("t6.restart_cycle", 128'(cycle), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
